mul_tree_sched: RTL
===================

MUL_TREE_SCHED -- requirements
Module: mul_tree_sched

Interface
REQ-001 Parameter TAG_W, default 4, SHALL set the width of the request/response tag.
REQ-002 Parameter TAG_DEPTH, default 8, SHALL set the maximum number of in-flight issues (tag FIFO depth, power of two).
REQ-003 Parameter WD_LIMIT, default 255, SHALL set the watchdog limit in cycles (used only when the watchdog is compiled in).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  SHALL form the request handshake; a transfer occurs when both are high.
REQ-007 req_mode  in  2  SHALL select the tree mode: 0 two-input, 1 three-input, 2 four-input, 3 six/two-input.
REQ-008 req_operands  in  128  SHALL carry four 32-bit lanes, each holding two bf16 operands {a[31:16], b[15:0]}.
REQ-009 req_tag  in  TAG_W  SHALL carry the requester's identifier.
REQ-010 tree_mul_ins / tree_mul_stb / tree_mode  out  128 / 1 / 2  SHALL drive the multiplier tree.
REQ-011 tree_outputs / tree_stbs  in  64 / 4  SHALL receive the tree's bf16 results and per-lane strobes.
REQ-012 rsp_valid / rsp_data / rsp_lanes / rsp_tag  out  1 / 64 / 4 / TAG_W  SHALL return results; there is no back-pressure.
REQ-013 err_flags  out  2  SHALL report errors: bit0 = spurious strobe, bit1 = watchdog timeout.

Function
REQ-014 An accepted request at cycle t SHALL put req_operands onto tree_mul_ins, registered, with tree_mul_stb=1 at t+1; otherwise tree_mul_stb SHALL be 0 and tree_mul_ins SHALL hold its last value.
REQ-015 tree_mode SHALL be driven from the registered cur_mode and SHALL change only while the in-flight count is 0.
REQ-016 An in-flight counter (0..TAG_DEPTH) SHALL increment on issue and decrement on response; when both occur in the same cycle it SHALL be unchanged.
REQ-017 req_tag SHALL be pushed into an in-order tag FIFO on issue and popped when any tree_stbs bit is high.
REQ-018 req_ready SHALL be 0 when the count equals TAG_DEPTH, when the state is DRAIN, or when err_flags[1] is set.
REQ-019 States: IDLE (count=0), RUN (count>0, same mode), DRAIN (mode change pending).
REQ-020 In IDLE, a request SHALL be accepted in any mode; cur_mode SHALL load req_mode in the same cycle and the state SHALL go to RUN.
REQ-021 In RUN, a request with req_mode equal to cur_mode SHALL be accepted; a request with a different req_mode SHALL be held off (req_ready=0) and the state SHALL go to DRAIN.
REQ-022 In DRAIN, the state SHALL go to IDLE when the count reaches 0, so the new mode issues no earlier than the following cycle.
REQ-023 In RUN, when the count reaches 0 with no accepted issue that cycle, the state SHALL go to IDLE.
REQ-024 On any tree_stbs bit high with a non-empty FIFO, the block SHALL, on the next cycle, set rsp_valid=1, rsp_data=tree_outputs, rsp_lanes=tree_stbs and rsp_tag=popped tag.
REQ-025 Outside a response cycle, rsp_valid SHALL be 0 and rsp_data, rsp_lanes and rsp_tag SHALL hold their values.
REQ-026 A tree_stbs bit high while the FIFO is empty SHALL be dropped, SHALL not change the count, and SHALL set err_flags[0], which is sticky until rst.
REQ-027 FIFO pointers SHALL wrap modulo TAG_DEPTH; full and empty SHALL be derived from the count, not from pointer equality alone.

Reset
REQ-028 rst SHALL clear to 0 the following: state (IDLE), cur_mode, count, FIFO pointers, tree_mul_stb, tree_mul_ins, rsp_valid, rsp_data, rsp_lanes, rsp_tag, err_flags and the watchdog counter.
REQ-029 req_ready SHALL be 0 during the rst cycle and SHALL be 1 the cycle after.
REQ-030 rst asserted mid-operation SHALL discard in-flight tags; the tree shares rst, so no stale strobes are expected.

Configuration
REQ-031 With MUL_SCHED_WATCHDOG_EN defined, a counter SHALL increment each cycle with count>0 and no tree_stbs, and SHALL clear on any strobe or when count=0.
REQ-032 With MUL_SCHED_WATCHDOG_EN defined, when that counter reaches WD_LIMIT, err_flags[1] SHALL set (sticky) and the count and FIFO SHALL flush to empty.
REQ-033 Without MUL_SCHED_WATCHDOG_EN, err_flags[1] SHALL be tied to 0 and no watchdog logic SHALL exist.

Verification
REQ-034 Scenario, single issue: mode 0, operands lane0 = 0x3F80_4000, tag 5; tree strobe 0001 with output 0x4000 -> tree_mul_stb pulses 1 cycle after acceptance; rsp_valid with rsp_tag=5, rsp_data[15:0]=0x4000, rsp_lanes=0001.
REQ-035 Scenario, back-to-back: 8 mode-2 requests, tags 0..7, strobes withheld -> req_ready=0 after the 8th; releasing strobes returns tags 0..7 in order and req_ready returns to 1.
REQ-036 Scenario, mode switch: 3 mode-0 issues in flight, then a mode-1 request -> DRAIN; tree_mode stays 0 until the third response; the mode-1 request issues 2 cycles after count=0.
REQ-037 Scenario, simultaneous events: issue and strobe in the same cycle at count=4 -> count stays 4; FIFO order is preserved across pointer wrap (20 issues).
REQ-038 Scenario, spurious strobe: strobe 0010 with the FIFO empty -> no rsp_valid; err_flags=01.
REQ-039 Scenario, reset/watchdog: rst mid-flight with count=3 -> all outputs 0 and req_ready=1 next cycle; with MUL_SCHED_WATCHDOG_EN, 1 issue and no strobe -> err_flags[1]=1 after 255 cycles and req_ready=0.

Source files
------------

// File: rtl/mul_tree_sched.sv
// In-order tag scheduler for a bf16 multiplier tree with mode-change draining.
// Optional watchdog: define MUL_SCHED_WATCHDOG_EN.
module mul_tree_sched #(
  parameter int TAG_W     = 4,
  parameter int TAG_DEPTH = 8,
  parameter int WD_LIMIT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_mode,
  input  logic [127:0]       req_operands,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [127:0]       tree_mul_ins,
  output logic               tree_mul_stb,
  output logic [1:0]         tree_mode,
  input  logic [63:0]        tree_outputs,
  input  logic [3:0]         tree_stbs,
  output logic               rsp_valid,
  output logic [63:0]        rsp_data,
  output logic [3:0]         rsp_lanes,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [1:0]         err_flags
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         cur_mode_q, cur_mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0]   tag_mem [TAG_DEPTH];
  logic               stb_q, stb_d;
  logic [127:0]       ins_q, ins_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic [3:0]         rsp_lanes_q, rsp_lanes_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               spur_q, spur_d;

  logic full, empty, any_stb, mode_hold;
  logic push, pop;
  logic wd_fire, wd_err;

`ifdef MUL_SCHED_WATCHDOG_EN
  localparam int WCW = $clog2(WD_LIMIT + 1);
  logic [WCW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_err_q, wd_err_d;

  assign wd_err  = wd_err_q;
  assign wd_fire = !empty && !any_stb &&
                   (wd_cnt_q == WCW'(WD_LIMIT - 1));

  always_comb begin
    wd_err_d = wd_err_q | wd_fire;
    wd_cnt_d = wd_cnt_q;
    if (empty || any_stb || wd_fire)
      wd_cnt_d = '0;
    else
      wd_cnt_d = wd_cnt_q + WCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end
`else
  assign wd_err  = 1'b0;
  assign wd_fire = 1'b0;
`endif

  assign full      = (cnt_q == CW'(TAG_DEPTH));
  assign empty     = (cnt_q == '0);
  assign any_stb   = |tree_stbs;
  // A mismatched mode blocks ready independent of valid
  assign mode_hold = (state_q == RUN) && (req_mode != cur_mode_q);
  assign req_ready = !rst && !full && (state_q != DRAIN) &&
                     !wd_err && !wd_fire && !mode_hold;
  assign push      = req_valid && req_ready;
  assign pop       = any_stb && !empty;

  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    stb_d       = push;
    ins_d       = push ? req_operands : ins_q;
    rsp_valid_d = pop;
    rsp_data_d  = rsp_data_q;
    rsp_lanes_d = rsp_lanes_q;
    rsp_tag_d   = rsp_tag_q;
    spur_d      = spur_q | (any_stb && empty);

    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (pop) begin
      rsp_data_d  = tree_outputs;
      rsp_lanes_d = tree_stbs;
      rsp_tag_d   = tag_mem[rd_ptr_q];
    end

    unique case (state_q)
      IDLE: begin
        if (push) begin
          state_d    = RUN;
          cur_mode_d = req_mode;
        end
      end
      RUN: begin
        if (req_valid && mode_hold)
          state_d = DRAIN;
        else if (cnt_d == '0 && !push)
          state_d = IDLE;
      end
      DRAIN: begin
        if (empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wd_fire) begin
      state_d  = IDLE;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_mode_q  <= 2'd0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stb_q       <= 1'b0;
      ins_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_lanes_q <= '0;
      rsp_tag_q   <= '0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_mode_q  <= cur_mode_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stb_q       <= stb_d;
      ins_q       <= ins_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_lanes_q <= rsp_lanes_d;
      rsp_tag_q   <= rsp_tag_d;
      spur_q      <= spur_d;
    end
  end

  // Tag storage needs no reset; occupancy lives in cnt_q
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= req_tag;
  end

  assign tree_mul_ins = ins_q;
  assign tree_mul_stb = stb_q;
  assign tree_mode    = cur_mode_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_lanes    = rsp_lanes_q;
  assign rsp_tag      = rsp_tag_q;
  assign err_flags    = {wd_err, spur_q};

endmodule
